mem_arbiter: RTL and testbench

- Sole owner of the byte-serial 8-bit RAM/IO port.
- Serves two requesters:
  - the instruction fetch stage, which reads 32-bit instruction words;
  - the load/store buffer (LSB), which does byte/half/word loads and stores.
- Assembles or splits multi-byte accesses little-endian, gives the LSB priority, and aborts speculative reads on a pipeline clear.
- Sits between the core and the external memory bus.

---
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter for the byte-serial 8-bit RAM/IO port. It serves instruction fetch and the load/store
// buffer, with the LSB taking priority, and assembles or splits little-endian multi-byte accesses.
module mem_arbiter #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic [7:0]        mem_din,
    input  logic              io_buffer_full,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              lsb_req,
    input  logic              lsb_wr,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [1:0]        lsb_len,
    input  logic [31:0]       lsb_wdata,
    output logic              lsb_done,
    output logic [31:0]       lsb_rdata
);

    typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              if_done_q, if_done_d;
    logic              lsb_done_q, lsb_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       lsb_rdata_q, lsb_rdata_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] nxt_addr;
    logic [1:0]        nxt_cnt;

    function automatic logic [1:0] last_idx(input logic [1:0] len);
        case (len)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // IO writes must wait while the IO buffer cannot take another byte.
    function automatic logic io_stall(input logic full, input logic [ADDR_W-1:0] a);
        return full && (a[17:16] == IO_HI);
    endfunction

    assign nxt_addr = mem_a_q + ADDR_W'(1);
    assign nxt_cnt  = cnt_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        if_done_d   = if_done_q;
        lsb_done_d  = lsb_done_q;
        if_data_d   = if_data_q;
        lsb_rdata_d = lsb_rdata_q;
        asm_d       = asm_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                if (!clear && lsb_req) begin
                    mem_a_d = lsb_addr;
                    cnt_d   = 2'd0;
                    last_d  = last_idx(lsb_len);
                    asm_d   = 32'd0;
                    wdata_d = lsb_wdata;
                    if (lsb_wr) begin
                        state_d    = LS_WR;
                        mem_dout_d = lsb_wdata[7:0];
                        mem_wr_d   = !io_stall(io_buffer_full, lsb_addr);
                    end else begin
                        state_d  = LS_RD;
                        mem_wr_d = 1'b0;
                    end
                end else if (!clear && if_req) begin
                    state_d  = IF_RD;
                    mem_a_d  = if_addr;
                    cnt_d    = 2'd0;
                    last_d   = 2'd3;
                    asm_d    = 32'd0;
                    mem_wr_d = 1'b0;
                end
            end
            IF_RD, LS_RD: begin
                if (clear) begin
                    state_d  = IDLE;
                    mem_wr_d = 1'b0;
                    asm_d    = 32'd0;
                end else begin
                    asm_d[{cnt_q, 3'b000} +: 8] = mem_din;
                    if (cnt_q == last_q) begin
                        state_d = DONE;
                        if (state_q == IF_RD) begin
                            if_data_d = asm_d;
                            if_done_d = 1'b1;
                        end else begin
                            lsb_rdata_d = asm_d;
                            lsb_done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d   = nxt_cnt;
                        mem_a_d = nxt_addr;
                    end
                end
            end
            LS_WR: begin
                // mem_wr_q high means byte cnt_q is being written at this edge.
                if (mem_wr_q) begin
                    if (cnt_q == last_q) begin
                        state_d    = DONE;
                        mem_wr_d   = 1'b0;
                        lsb_done_d = 1'b1;
                    end else begin
                        cnt_d      = nxt_cnt;
                        mem_a_d    = nxt_addr;
                        mem_dout_d = wdata_q[{nxt_cnt, 3'b000} +: 8];
                        mem_wr_d   = !io_stall(io_buffer_full, nxt_addr);
                    end
                end else begin
                    mem_wr_d = !io_stall(io_buffer_full, mem_a_q);
                end
            end
            DONE: begin
                state_d    = IDLE;
                if_done_d  = 1'b0;
                lsb_done_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            last_q      <= 2'd0;
            mem_a_q     <= '0;
            mem_dout_q  <= 8'd0;
            mem_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
            if_data_q   <= 32'd0;
            lsb_rdata_q <= 32'd0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            if_done_q   <= if_done_d;
            lsb_done_q  <= lsb_done_d;
            if_data_q   <= if_data_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

    // Assembly and store-data buffers are always loaded before use, so they carry no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            asm_q   <= asm_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q;
    assign if_done   = if_done_q;
    assign lsb_done  = lsb_done_q;
    assign if_data   = if_data_q;
    assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a RAM model on the byte bus, with scoreboard queues for done results
// and bus writes.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        lsb_req, lsb_wr, lsb_done;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
    logic [1:0]  lsb_len;

    int nvec = 0;
    int nerr = 0;

    typedef struct packed {
        logic        is_if;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [39:0] expw_q[$];
    logic [39:0] obs_w[$];
    logic [7:0]  ram [0:262143];

    mem_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
    );

    always #5 clk_in = ~clk_in;

    assign mem_din = ram[mem_a[17:0]];

    always @(posedge clk_in) begin
        if (!rst_in && rdy_in && mem_wr) begin
            ram[mem_a[17:0]] <= mem_dout;
            obs_w.push_back({mem_a, mem_dout});
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (if_done || lsb_done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0; lsb_req = 1'b0; lsb_wr = 1'b0;
        lsb_addr = '0; lsb_len = 2'd0; lsb_wdata = '0;
        #3;
        nvec++;
        if ({mem_a, mem_dout, mem_wr} !== 41'd0) begin
            nerr++; $display("FAIL reset_bus got a=%h d=%h wr=%b want 0", mem_a, mem_dout, mem_wr);
        end
        nvec++;
        if ({if_done, lsb_done} !== 2'b00) begin
            nerr++; $display("FAIL reset_done got %b%b want 00", if_done, lsb_done);
        end
        nvec++;
        if ({if_data, lsb_rdata} !== 64'd0) begin
            nerr++; $display("FAIL reset_data got %h/%h want 0", if_data, lsb_rdata);
        end
        tick(); tick();
        rst_in = 1'b0;
    endtask

    task automatic test_word_fetch();
        exp_t e;
        exp_q.delete();
        ram[18'h100] = 8'h13; ram[18'h101] = 8'h05; ram[18'h102] = 8'hA0; ram[18'h103] = 8'h00;
        if_addr = 32'h100; if_req = 1'b1;
        exp_q.push_back('{is_if: 1'b1, data: 32'h00A00513});
        for (int k = 0; k < 4; k++) begin
            tick();
            nvec++;
            if (mem_a !== 32'h100 + k || mem_wr !== 1'b0 || if_done !== 1'b0) begin
                nerr++; $display("FAIL fetch_addr%0d got a=%h wr=%b done=%b want a=%h", k, mem_a, mem_wr, if_done, 32'h100 + k);
            end
        end
        tick();
        nvec++;
        if (!(if_done === 1'b1 && lsb_done === 1'b0)) begin
            nerr++; $display("FAIL fetch_done got if=%b lsb=%b want 1/0", if_done, lsb_done);
        end else begin
            e = exp_q.pop_front();
            nvec++;
            if (if_data !== e.data) begin
                nerr++; $display("FAIL fetch_data got %h want %h", if_data, e.data);
            end
        end
        if_req = 1'b0;
        tick();
        nvec++;
        if ({if_done, lsb_done} !== 2'b00) begin
            nerr++; $display("FAIL fetch_pulse got %b%b want 00", if_done, lsb_done);
        end
        tick();
        nvec++;
        if (mem_a !== 32'h103 || if_done !== 1'b0) begin
            nerr++; $display("FAIL fetch_idle got a=%h done=%b want a=103 done=0", mem_a, if_done);
        end
    endtask

    task automatic test_priority();
        exp_t e;
        int   cyc;
        exp_q.delete();
        ram[18'h200] = 8'hFF;
        ram[18'h104] = 8'h11; ram[18'h105] = 8'h22; ram[18'h106] = 8'h33; ram[18'h107] = 8'h44;
        lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h200; lsb_req = 1'b1;
        if_addr = 32'h104; if_req = 1'b1;
        exp_q.push_back('{is_if: 1'b0, data: 32'h000000FF});
        exp_q.push_back('{is_if: 1'b1, data: 32'h44332211});
        tick();
        nvec++;
        if (mem_a !== 32'h200) begin
            nerr++; $display("FAIL prio_accept got a=%h want 200", mem_a);
        end
        tick();
        e = exp_q.pop_front();
        nvec++;
        if ({if_done, lsb_done} !== {e.is_if, ~e.is_if} || lsb_rdata !== e.data) begin
            nerr++; $display("FAIL prio_lsb got if=%b lsb=%b data=%h want lsb data=%h", if_done, lsb_done, lsb_rdata, e.data);
        end
        lsb_req = 1'b0;
        tick();
        nvec++;
        if ({if_done, lsb_done} !== 2'b00 || mem_a !== 32'h200) begin
            nerr++; $display("FAIL prio_done_cycle got done=%b%b a=%h want 00 a=200", if_done, lsb_done, mem_a);
        end
        tick();
        nvec++;
        if (mem_a !== 32'h104) begin
            nerr++; $display("FAIL prio_fetch_start got a=%h want 104", mem_a);
        end
        wait_done(8, cyc);
        nvec++;
        if (cyc != 4) begin
            nerr++; $display("FAIL prio_fetch_lat got %0d want 4", cyc);
        end else begin
            e = exp_q.pop_front();
            nvec++;
            if ({if_done, lsb_done} !== {e.is_if, ~e.is_if} || if_data !== e.data) begin
                nerr++; $display("FAIL prio_fetch_data got %h want %h", if_data, e.data);
            end
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_half_store();
        int cyc;
        obs_w.delete(); expw_q.delete();
        expw_q.push_back({32'h300, 8'hCD});
        expw_q.push_back({32'h301, 8'hAB});
        lsb_wr = 1'b1; lsb_len = 2'd1; lsb_addr = 32'h300; lsb_wdata = 32'h1234ABCD; lsb_req = 1'b1;
        tick();
        nvec++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h300 || mem_dout !== 8'hCD) begin
            nerr++; $display("FAIL hst_first got wr=%b a=%h d=%h want 1 300 CD", mem_wr, mem_a, mem_dout);
        end
        wait_done(6, cyc);
        nvec++;
        if (cyc != 2 || lsb_done !== 1'b1 || if_done !== 1'b0 || mem_wr !== 1'b0) begin
            nerr++; $display("FAIL hst_done got cyc=%0d lsb=%b if=%b wr=%b want 2 1 0 0", cyc, lsb_done, if_done, mem_wr);
        end
        lsb_req = 1'b0;
        tick();
        nvec++;
        if (mem_wr !== 1'b0 || lsb_done !== 1'b0) begin
            nerr++; $display("FAIL hst_after got wr=%b done=%b want 0 0", mem_wr, lsb_done);
        end
        nvec++;
        if (obs_w.size() != expw_q.size()) begin
            nerr++; $display("FAIL hst_count got %0d want %0d", obs_w.size(), expw_q.size());
        end
        while (obs_w.size() > 0 && expw_q.size() > 0) begin
            logic [39:0] o, x;
            o = obs_w.pop_front(); x = expw_q.pop_front();
            nvec++;
            if (o !== x) begin
                nerr++; $display("FAIL hst_write got %h want %h", o, x);
            end
        end
        nvec++;
        if ({ram[18'h300], ram[18'h301], ram[18'h302]} !== 24'hCDAB00) begin
            nerr++; $display("FAIL hst_ram got %h%h%h want CDAB00", ram[18'h300], ram[18'h301], ram[18'h302]);
        end
    endtask

    task automatic test_clear_fetch();
        exp_t e;
        int   cyc;
        exp_q.delete();
        ram[18'h400] = 8'h78; ram[18'h401] = 8'h56; ram[18'h402] = 8'h34; ram[18'h403] = 8'h12;
        if_addr = 32'h100; if_req = 1'b1;
        tick(); tick();
        clear = 1'b1;
        tick();
        nvec++;
        if ({if_done, lsb_done} !== 2'b00) begin
            nerr++; $display("FAIL clr_nodone got %b%b want 00", if_done, lsb_done);
        end
        clear = 1'b0; if_addr = 32'h400;
        exp_q.push_back('{is_if: 1'b1, data: 32'h12345678});
        tick();
        nvec++;
        if (mem_a !== 32'h400) begin
            nerr++; $display("FAIL clr_restart got a=%h want 400", mem_a);
        end
        wait_done(8, cyc);
        nvec++;
        if (cyc != 4) begin
            nerr++; $display("FAIL clr_lat got %0d want 4", cyc);
        end else begin
            e = exp_q.pop_front();
            nvec++;
            if ({if_done, lsb_done} !== {e.is_if, ~e.is_if} || if_data !== e.data) begin
                nerr++; $display("FAIL clr_data got %h want %h", if_data, e.data);
            end
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_io_stall();
        int ndone;
        obs_w.delete(); expw_q.delete();
        expw_q.push_back({32'h30000, 8'hEF});
        expw_q.push_back({32'h30001, 8'hBE});
        expw_q.push_back({32'h30002, 8'hAD});
        expw_q.push_back({32'h30003, 8'hDE});
        io_buffer_full = 1'b1;
        lsb_wr = 1'b1; lsb_len = 2'd2; lsb_addr = 32'h30000; lsb_wdata = 32'hDEADBEEF; lsb_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            clear = (i == 0);
            nvec++;
            if (mem_wr !== 1'b0) begin
                nerr++; $display("FAIL io_stall%0d got wr=%b want 0", i, mem_wr);
            end
        end
        io_buffer_full = 1'b0; clear = 1'b0;
        nvec++;
        if (obs_w.size() != 0) begin
            nerr++; $display("FAIL io_nowrite got %0d writes want 0", obs_w.size());
        end
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (lsb_done) begin ndone++; lsb_req = 1'b0; end
        end
        nvec++;
        if (ndone != 1) begin
            nerr++; $display("FAIL io_done_count got %0d want 1", ndone);
        end
        nvec++;
        if (obs_w.size() != expw_q.size()) begin
            nerr++; $display("FAIL io_count got %0d want %0d", obs_w.size(), expw_q.size());
        end
        while (obs_w.size() > 0 && expw_q.size() > 0) begin
            logic [39:0] o, x;
            o = obs_w.pop_front(); x = expw_q.pop_front();
            nvec++;
            if (o !== x) begin
                nerr++; $display("FAIL io_write got %h want %h", o, x);
            end
        end
        // Outside the IO region a full buffer must not hold up the store.
        io_buffer_full = 1'b1;
        lsb_len = 2'd0; lsb_addr = 32'h20010; lsb_wdata = 32'h0000005A; lsb_req = 1'b1;
        tick();
        nvec++;
        if (mem_wr !== 1'b1) begin
            nerr++; $display("FAIL io_nonio_wr got %b want 1", mem_wr);
        end
        tick();
        lsb_req = 1'b0; io_buffer_full = 1'b0;
        tick();
        nvec++;
        if (ram[18'h20010] !== 8'h5A) begin
            nerr++; $display("FAIL io_nonio_ram got %h want 5A", ram[18'h20010]);
        end
    endtask

    task automatic test_rdy_freeze();
        exp_t e;
        int   cyc;
        exp_q.delete();
        if_addr = 32'h104; if_req = 1'b1;
        exp_q.push_back('{is_if: 1'b1, data: 32'h44332211});
        tick(); tick();
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            nvec++;
            if (mem_a !== 32'h105 || if_done !== 1'b0 || mem_wr !== 1'b0) begin
                nerr++; $display("FAIL rdy_hold%0d got a=%h done=%b wr=%b want 105 0 0", i, mem_a, if_done, mem_wr);
            end
        end
        rdy_in = 1'b1;
        wait_done(6, cyc);
        nvec++;
        if (cyc != 3) begin
            nerr++; $display("FAIL rdy_lat got %0d want 3", cyc);
        end else begin
            e = exp_q.pop_front();
            nvec++;
            if ({if_done, lsb_done} !== {e.is_if, ~e.is_if} || if_data !== e.data) begin
                nerr++; $display("FAIL rdy_data got %h want %h", if_data, e.data);
            end
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [31:0] want_a [4];
        exp_q.delete();
        want_a[0] = 32'hFFFFFFFE; want_a[1] = 32'hFFFFFFFF; want_a[2] = 32'h0; want_a[3] = 32'h1;
        ram[18'h3FFFE] = 8'hAA; ram[18'h3FFFF] = 8'hBB; ram[18'h0] = 8'hCC; ram[18'h1] = 8'hDD;
        lsb_wr = 1'b0; lsb_len = 2'd3; lsb_addr = 32'hFFFFFFFE; lsb_req = 1'b1;
        exp_q.push_back('{is_if: 1'b0, data: 32'hDDCCBBAA});
        for (int k = 0; k < 4; k++) begin
            tick();
            nvec++;
            if (mem_a !== want_a[k]) begin
                nerr++; $display("FAIL wrap_addr%0d got %h want %h", k, mem_a, want_a[k]);
            end
        end
        tick();
        e = exp_q.pop_front();
        nvec++;
        if ({if_done, lsb_done} !== {e.is_if, ~e.is_if} || lsb_rdata !== e.data) begin
            nerr++; $display("FAIL wrap_data got done=%b%b %h want %h", if_done, lsb_done, lsb_rdata, e.data);
        end
        lsb_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        lsb_wr = 1'b1; lsb_len = 2'd2; lsb_addr = 32'h500; lsb_wdata = 32'hCAFEF00D; lsb_req = 1'b1;
        tick();
        nvec++;
        if (mem_wr !== 1'b1) begin
            nerr++; $display("FAIL rstw_active got wr=%b want 1", mem_wr);
        end
        tick();
        #1 rst_in = 1'b1;
        #1;
        nvec++;
        if ({mem_a, mem_dout, mem_wr, if_done, lsb_done} !== 43'd0 || {if_data, lsb_rdata} !== 64'd0) begin
            nerr++; $display("FAIL rstw_async got a=%h d=%h wr=%b data=%h/%h want 0", mem_a, mem_dout, mem_wr, if_data, lsb_rdata);
        end
        lsb_req = 1'b0;
        tick();
        rst_in = 1'b0;
        tick(); tick();
        nvec++;
        if (mem_wr !== 1'b0 || lsb_done !== 1'b0 || mem_a !== 32'h0) begin
            nerr++; $display("FAIL rstw_idle got wr=%b done=%b a=%h want 0 0 0", mem_wr, lsb_done, mem_a);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        exp_q.delete();
        if_addr = 32'h100; if_req = 1'b1;
        exp_q.push_back('{is_if: 1'b1, data: 32'h00A00513});
        wait_done(8, cyc);
        nvec++;
        if (cyc != 5) begin
            nerr++; $display("FAIL b2b_lat got %0d want 5", cyc);
        end else begin
            e = exp_q.pop_front();
            nvec++;
            if ({if_done, lsb_done} !== {e.is_if, ~e.is_if} || if_data !== e.data) begin
                nerr++; $display("FAIL b2b_data got %h want %h", if_data, e.data);
            end
        end
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        test_reset();
        test_word_fetch();
        test_priority();
        test_half_store();
        test_clear_fetch();
        test_io_stall();
        test_rdy_freeze();
        test_wrap();
        test_reset_mid_write();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
